// File: rtl/layer_compositor_if.sv
// Pixel bus between the sprite layers and the display output stage.
// Inputs carry per-layer hit/colour; outputs carry the composited pixel.
interface layer_compositor_if #(
    parameter int N_LAYERS = 13,
    parameter int CW       = 8
);
    logic                       i_de;
    logic                       i_v_sync;
    logic [N_LAYERS-1:0]        i_layer_en;
    logic [N_LAYERS-1:0]        i_hit;
    logic [N_LAYERS*3*CW-1:0]   i_rgb;
    logic [3*CW-1:0]            i_bg_rgb;
    logic [CW-1:0]              o_red;
    logic [CW-1:0]              o_green;
    logic [CW-1:0]              o_blue;
    logic                       o_de;
    logic [4:0]                 o_layer_idx;
    logic [N_LAYERS-1:0]        o_collide;
    logic                       o_frame_done;

    modport master (
        output i_de, i_v_sync, i_layer_en, i_hit, i_rgb, i_bg_rgb,
        input  o_red, o_green, o_blue, o_de, o_layer_idx,
        input  o_collide, o_frame_done
    );

    modport slave (
        input  i_de, i_v_sync, i_layer_en, i_hit, i_rgb, i_bg_rgb,
        output o_red, o_green, o_blue, o_de, o_layer_idx,
        output o_collide, o_frame_done
    );
endinterface

// File: rtl/layer_compositor.sv
// Two-stage priority compositor for N sprite layers over a background,
// with colour-key transparency and per-frame player collision flags.
module layer_compositor #(
    parameter int              N_LAYERS   = 13,
    parameter int              CW         = 8,
    parameter int              PLAYER_IDX = 6,
    parameter bit              KEY_EN     = 1'b1,
    parameter logic [3*CW-1:0] KEY_RGB    = 24'hFF00FF
) (
    input logic            i_clk,
    input logic            i_rst,
    layer_compositor_if.slave bus
);
    localparam int PW = 3 * CW;
    localparam logic [N_LAYERS-1:0] PMASK =
        {{(N_LAYERS-1){1'b0}}, 1'b1} << PLAYER_IDX;

    generate
        if (N_LAYERS < 2 || N_LAYERS > 31 ||
            PLAYER_IDX < 0 || PLAYER_IDX >= N_LAYERS) begin : g_bad_cfg
            $error("layer_compositor: illegal N_LAYERS/PLAYER_IDX");
        end
    endgenerate

    logic [N_LAYERS-1:0]    vis_c;
    logic [N_LAYERS-1:0]    contrib_c;
    logic                   boundary_c;

    logic [N_LAYERS-1:0]    vis_q;
    logic [N_LAYERS*PW-1:0] rgb_q;
    logic [PW-1:0]          bg_q;
    logic                   de1_q;

    logic [4:0]             idx_c;
    logic [PW-1:0]          sel_c;

    logic [CW-1:0]          red_q, green_q, blue_q;
    logic                   de2_q;
    logic [4:0]             idx_q;

    logic [N_LAYERS-1:0]    acc_q, acc_d;
    logic [N_LAYERS-1:0]    collide_q, collide_d;
    logic                   done_q, done_d;
    logic                   vs_q;
    logic                   armed_q, armed_d;

    always_comb begin
        vis_c = '0;
        for (int k = 0; k < N_LAYERS; k++) begin
            vis_c[k] = bus.i_hit[k] & bus.i_layer_en[k] &
                ~(KEY_EN && (bus.i_rgb[k*PW +: PW] == KEY_RGB));
        end
    end

    // Descending scan so the lowest visible index is written last.
    always_comb begin
        idx_c = 5'd31;
        sel_c = bg_q;
        for (int k = N_LAYERS - 1; k >= 0; k--) begin
            if (vis_q[k]) begin
                idx_c = 5'(k);
                sel_c = rgb_q[k*PW +: PW];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            vis_q   <= '0;
            rgb_q   <= '0;
            bg_q    <= '0;
            de1_q   <= 1'b0;
            red_q   <= '0;
            green_q <= '0;
            blue_q  <= '0;
            de2_q   <= 1'b0;
            idx_q   <= 5'd31;
        end else begin
            vis_q   <= vis_c;
            rgb_q   <= bus.i_rgb;
            bg_q    <= bus.i_bg_rgb;
            de1_q   <= bus.i_de;
            red_q   <= de1_q ? sel_c[2*CW +: CW] : '0;
            green_q <= de1_q ? sel_c[CW +: CW]   : '0;
            blue_q  <= de1_q ? sel_c[0 +: CW]    : '0;
            de2_q   <= de1_q;
            idx_q   <= idx_c;
        end
    end

    // armed blocks a boundary until v_sync has been seen low after reset.
    assign boundary_c = bus.i_v_sync & ~vs_q & armed_q;
    assign contrib_c  = (bus.i_de && vis_c[PLAYER_IDX]) ?
                        (vis_c & ~PMASK) : '0;

    always_comb begin
        acc_d     = acc_q | contrib_c;
        collide_d = collide_q;
        done_d    = 1'b0;
        armed_d   = armed_q | ~bus.i_v_sync;
        if (boundary_c) begin
            collide_d = acc_q | contrib_c;
            acc_d     = '0;
            done_d    = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            acc_q     <= '0;
            collide_q <= '0;
            done_q    <= 1'b0;
            vs_q      <= 1'b0;
            armed_q   <= ~bus.i_v_sync;
        end else begin
            acc_q     <= acc_d;
            collide_q <= collide_d;
            done_q    <= done_d;
            vs_q      <= bus.i_v_sync;
            armed_q   <= armed_d;
        end
    end

    assign bus.o_red        = red_q;
    assign bus.o_green      = green_q;
    assign bus.o_blue       = blue_q;
    assign bus.o_de         = de2_q;
    assign bus.o_layer_idx  = idx_q;
    assign bus.o_collide    = collide_q;
    assign bus.o_frame_done = done_q;
endmodule
